// File: rtl/solver_pkg.sv
// Shared sizes, lane state encoding and board cell addressing for the
// nonogram line-deduction core.
package solver_pkg;

  localparam int MAX_ROWS  = 11;
  localparam int MAX_COLS  = 11;
  localparam int OPT_W     = 16;
  localparam int CNT_W     = 7;
  localparam int MAX_LINES = MAX_ROWS + MAX_COLS;
  localparam int MAX_LEN   = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
  localparam int NCELLS    = MAX_ROWS * MAX_COLS;
  localparam int CELL_W    = $clog2(NCELLS);

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_INDEX  = 2'd1,
    LANE_OPTS   = 2'd2,
    LANE_COMMIT = 2'd3
  } lane_state_e;

  // Row-major cell address; the board is packed with the runtime column count.
  function automatic logic [CELL_W-1:0] cell_idx(input logic [3:0] r,
                                                 input logic [3:0] c,
                                                 input logic [3:0] ncols);
    return CELL_W'(r) * CELL_W'(ncols) + CELL_W'(c);
  endfunction

endpackage

// File: rtl/line_lane.sv
// One deduction lane: pops a line index and its options, filters them against
// a snapshot of the line, and emits the agreed cells as a commit mask/value.
module line_lane
  import solver_pkg::*;
#(
  parameter bit IS_ROW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_started,
  input  logic                         i_solved,
  input  logic [OPT_W-1:0]             i_option,
  input  logic [3:0]                   i_num_rows,
  input  logic [3:0]                   i_num_cols,
  input  logic [MAX_LINES*CNT_W-1:0]   i_old_options_amnt,
  input  logic [NCELLS-1:0]            i_known,
  input  logic [NCELLS-1:0]            i_assigned,
  output logic                         o_read,
  output logic                         o_put_back,
  output logic [OPT_W-1:0]             o_new_option,
  output logic [3:0]                   o_line,
  output logic [MAX_LEN-1:0]           o_mask,
  output logic [MAX_LEN-1:0]           o_value
);

  lane_state_e        r_state;
  logic               r_line_ok;
  logic [3:0]         r_pos;
  logic [MAX_LEN-1:0] r_snap_known, r_snap_assigned, r_len_mask;
  logic [MAX_LEN-1:0] r_and, r_or;
  logic [CNT_W-1:0]   r_cnt, r_hits;

  logic [OPT_W-1:0]   w_lo, w_hi;
  logic               w_in_range;
  logic [3:0]         w_pos, w_len;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_cnt_tab [32];
  logic [CELL_W-1:0]  w_cell [MAX_LEN];
  logic [MAX_LEN-1:0] w_len_mask, w_snap_known, w_snap_assigned;
  logic               w_consistent;

  // Rows occupy indices [0, num_rows); columns follow at [num_rows, num_rows+num_cols).
  assign w_lo       = IS_ROW ? '0 : {{(OPT_W-4){1'b0}}, i_num_rows};
  assign w_hi       = w_lo + {{(OPT_W-4){1'b0}}, (IS_ROW ? i_num_rows : i_num_cols)};
  assign w_in_range = (i_option >= w_lo) && (i_option < w_hi);
  assign w_pos      = i_option[3:0] - w_lo[3:0];
  assign w_len      = IS_ROW ? i_num_cols : i_num_rows;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cnt
      if (gi < MAX_LINES) begin : g_used
        assign w_cnt_tab[gi] = i_old_options_amnt[gi*CNT_W +: CNT_W];
      end else begin : g_pad
        assign w_cnt_tab[gi] = '0;
      end
    end
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_snap
      assign w_cell[gi]          = IS_ROW ? cell_idx(w_pos, 4'(gi), i_num_cols)
                                          : cell_idx(4'(gi), w_pos, i_num_cols);
      assign w_len_mask[gi]      = 4'(gi) < w_len;
      assign w_snap_known[gi]    = w_len_mask[gi] && (w_cell[gi] < CELL_W'(NCELLS))
                                   && i_known[w_cell[gi]];
      assign w_snap_assigned[gi] = w_len_mask[gi] && (w_cell[gi] < CELL_W'(NCELLS))
                                   && i_assigned[w_cell[gi]];
    end
  endgenerate

  assign w_count      = (i_option[OPT_W-1:5] == '0) ? w_cnt_tab[i_option[4:0]] : '0;
  assign w_consistent = ((i_option[MAX_LEN-1:0] ^ r_snap_assigned) & r_snap_known) == '0;

  // Options of a foreign line are returned untouched so the FIFO keeps them.
  assign o_read       = (r_state == LANE_INDEX) || (r_state == LANE_OPTS);
  assign o_put_back   = (r_state == LANE_INDEX) ||
                        ((r_state == LANE_OPTS) && (!r_line_ok || w_consistent));
  assign o_new_option = o_put_back ? i_option : '0;
  assign o_line       = r_pos;
  assign o_mask       = ((r_state == LANE_COMMIT) && r_line_ok && (r_hits != '0))
                        ? ((r_and | ~r_or) & r_len_mask) : '0;
  assign o_value      = r_and & r_len_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= LANE_IDLE;
      r_line_ok       <= 1'b0;
      r_pos           <= '0;
      r_snap_known    <= '0;
      r_snap_assigned <= '0;
      r_len_mask      <= '0;
      r_and           <= '0;
      r_or            <= '0;
      r_cnt           <= '0;
      r_hits          <= '0;
    end else begin
      case (r_state)
        LANE_IDLE: begin
          if (i_started && !i_solved) r_state <= LANE_INDEX;
        end
        LANE_INDEX: begin
          r_line_ok       <= w_in_range;
          r_pos           <= w_pos;
          r_snap_known    <= w_snap_known;
          r_snap_assigned <= w_snap_assigned;
          r_len_mask      <= w_len_mask;
          r_cnt           <= w_count;
          r_and           <= '1;
          r_or            <= '0;
          r_hits          <= '0;
          r_state         <= (w_count == '0) ? LANE_COMMIT : LANE_OPTS;
        end
        LANE_OPTS: begin
          if (r_line_ok && w_consistent) begin
            r_and  <= r_and & i_option[MAX_LEN-1:0];
            r_or   <= r_or | i_option[MAX_LEN-1:0];
            r_hits <= r_hits + 1'b1;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= LANE_COMMIT;
        end
        default: begin
          r_state <= i_solved ? LANE_IDLE : LANE_INDEX;
        end
      endcase
    end
  end

endmodule

// File: rtl/parallel_solver.sv
// Row and column deduction lanes sharing one board; owns the board merge
// (row lane wins on value conflicts) and the sticky solved flag.
module parallel_solver
  import solver_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       started,
  input  logic [OPT_W-1:0]           option_r,
  input  logic [OPT_W-1:0]           option_c,
  input  logic [3:0]                 num_rows,
  input  logic [3:0]                 num_cols,
  input  logic [MAX_LINES*CNT_W-1:0] old_options_amnt,
  output logic                       read_from_fifo_r,
  output logic                       read_from_fifo_c,
  output logic [NCELLS-1:0]          assigned,
  output logic [NCELLS-1:0]          known,
  output logic [OPT_W-1:0]           new_option_r,
  output logic [OPT_W-1:0]           new_option_c,
  output logic                       put_back_to_FIFO_r,
  output logic                       put_back_to_FIFO_c,
  output logic                       solved
);

  logic [NCELLS-1:0]  r_known, r_assigned;
  logic               r_solved;
  logic [3:0]         w_row_line, w_col_line;
  logic [MAX_LEN-1:0] w_row_mask, w_row_value, w_col_mask, w_col_value;
  logic [CELL_W-1:0]  w_row_cell [MAX_LEN];
  logic [CELL_W-1:0]  w_col_cell [MAX_LEN];
  logic [NCELLS-1:0]  w_row_hit, w_row_val, w_col_hit, w_col_val;
  logic [NCELLS-1:0]  w_any_hit, w_new_val, w_known_next, w_assigned_next;
  logic [NCELLS-1:0]  w_active;
  logic [7:0]         w_total;
  logic               w_full;

  line_lane #(.IS_ROW(1'b1)) u_row_lane (
    .clk(clk), .rst(rst), .i_started(started), .i_solved(r_solved),
    .i_option(option_r), .i_num_rows(num_rows), .i_num_cols(num_cols),
    .i_old_options_amnt(old_options_amnt), .i_known(r_known), .i_assigned(r_assigned),
    .o_read(read_from_fifo_r), .o_put_back(put_back_to_FIFO_r), .o_new_option(new_option_r),
    .o_line(w_row_line), .o_mask(w_row_mask), .o_value(w_row_value)
  );

  line_lane #(.IS_ROW(1'b0)) u_col_lane (
    .clk(clk), .rst(rst), .i_started(started), .i_solved(r_solved),
    .i_option(option_c), .i_num_rows(num_rows), .i_num_cols(num_cols),
    .i_old_options_amnt(old_options_amnt), .i_known(r_known), .i_assigned(r_assigned),
    .o_read(read_from_fifo_c), .o_put_back(put_back_to_FIFO_c), .o_new_option(new_option_c),
    .o_line(w_col_line), .o_mask(w_col_mask), .o_value(w_col_value)
  );

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_map
      assign w_row_cell[gi] = cell_idx(w_row_line, 4'(gi), num_cols);
      assign w_col_cell[gi] = cell_idx(4'(gi), w_col_line, num_cols);
    end
    for (gi = 0; gi < NCELLS; gi++) begin : g_active
      assign w_active[gi] = 8'(gi) < w_total;
    end
  endgenerate

  always_comb begin
    w_row_hit = '0;
    w_row_val = '0;
    w_col_hit = '0;
    w_col_val = '0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (w_row_mask[j] && (w_row_cell[j] < CELL_W'(NCELLS))) begin
        w_row_hit[w_row_cell[j]] = 1'b1;
        w_row_val[w_row_cell[j]] = w_row_value[j];
      end
      if (w_col_mask[j] && (w_col_cell[j] < CELL_W'(NCELLS))) begin
        w_col_hit[w_col_cell[j]] = 1'b1;
        w_col_val[w_col_cell[j]] = w_col_value[j];
      end
    end
  end

  // Cells already known keep their value even if a late commit disagrees.
  assign w_any_hit       = w_row_hit | w_col_hit;
  assign w_new_val       = (w_row_hit & w_row_val) | (~w_row_hit & w_col_val);
  assign w_known_next    = r_known | w_any_hit;
  assign w_assigned_next = (r_assigned & (r_known | ~w_any_hit)) |
                           (~r_known & w_any_hit & w_new_val);

  assign w_total = {4'd0, num_rows} * {4'd0, num_cols};
  assign w_full  = (w_total != 8'd0) && (&(r_known | ~w_active));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_known    <= '0;
      r_assigned <= '0;
      r_solved   <= 1'b0;
    end else begin
      r_known    <= w_known_next;
      r_assigned <= w_assigned_next;
      r_solved   <= r_solved | w_full;
    end
  end

  assign known    = r_known;
  assign assigned = r_assigned;
  assign solved   = r_solved;

endmodule

// File: tb/tb_parallel_solver.sv
// Scenario bench for parallel_solver: FIFO models feed both lanes and a
// scoreboard checks every push-back against the words expected to survive.
module tb_parallel_solver;
  import solver_pkg::*;

  localparam logic [OPT_W-1:0] FILL = 16'hFFFF;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic                       started = 1'b0;
  logic [OPT_W-1:0]           option_r = FILL;
  logic [OPT_W-1:0]           option_c = FILL;
  logic [3:0]                 num_rows = 4'd11;
  logic [3:0]                 num_cols = 4'd11;
  logic [MAX_LINES*CNT_W-1:0] amnt = '0;
  logic                       read_from_fifo_r, read_from_fifo_c;
  logic [NCELLS-1:0]          assigned, known;
  logic [OPT_W-1:0]           new_option_r, new_option_c;
  logic                       put_back_to_FIFO_r, put_back_to_FIFO_c;
  logic                       solved;

  logic [OPT_W-1:0] fifo_r[$], fifo_c[$], exp_r[$], exp_c[$];
  int total = 0;
  int bad = 0;
  int reads_r = 0;
  int reads_c = 0;

  parallel_solver dut (
    .clk(clk), .rst(rst_n), .started(started),
    .option_r(option_r), .option_c(option_c),
    .num_rows(num_rows), .num_cols(num_cols), .old_options_amnt(amnt),
    .read_from_fifo_r(read_from_fifo_r), .read_from_fifo_c(read_from_fifo_c),
    .assigned(assigned), .known(known),
    .new_option_r(new_option_r), .new_option_c(new_option_c),
    .put_back_to_FIFO_r(put_back_to_FIFO_r), .put_back_to_FIFO_c(put_back_to_FIFO_c),
    .solved(solved)
  );

  always #5 clk = ~clk;

  // FIFO heads change on the falling edge; strobes are sampled 1 ns later.
  always begin
    logic [OPT_W-1:0] e;
    @(negedge clk);
    option_r = (fifo_r.size() != 0) ? fifo_r[0] : FILL;
    option_c = (fifo_c.size() != 0) ? fifo_c[0] : FILL;
    #1;
    if (rst_n) begin
      if (read_from_fifo_r) reads_r++;
      if (read_from_fifo_c) reads_c++;
      if (put_back_to_FIFO_r && fifo_r.size() != 0) begin
        total++;
        if (exp_r.size() == 0) begin
          bad++;
          $display("FAIL push_r unexpected got=%h need=none", new_option_r);
        end else begin
          e = exp_r.pop_front();
          if (new_option_r !== e) begin
            bad++;
            $display("FAIL push_r got=%h need=%h", new_option_r, e);
          end else $display("push_r word=%h ok", new_option_r);
        end
      end
      if (put_back_to_FIFO_c && fifo_c.size() != 0) begin
        total++;
        if (exp_c.size() == 0) begin
          bad++;
          $display("FAIL push_c unexpected got=%h need=none", new_option_c);
        end else begin
          e = exp_c.pop_front();
          if (new_option_c !== e) begin
            bad++;
            $display("FAIL push_c got=%h need=%h", new_option_c, e);
          end else $display("push_c word=%h ok", new_option_c);
        end
      end
      if (read_from_fifo_r && fifo_r.size() != 0) void'(fifo_r.pop_front());
      if (read_from_fifo_c && fifo_c.size() != 0) void'(fifo_c.pop_front());
    end
  end

  task automatic set_counts(input int v);
    for (int i = 0; i < MAX_LINES; i++) amnt[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic apply_reset(input logic [3:0] nr, input logic [3:0] nc);
    rst_n = 1'b0;
    started = 1'b0;
    num_rows = nr;
    num_cols = nc;
    fifo_r.delete(); fifo_c.delete(); exp_r.delete(); exp_c.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reads_r = 0;
    reads_c = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 started = 1'b1;
    @(posedge clk); #1 started = 1'b0;
  endtask

  task automatic load_r(input logic [OPT_W-1:0] w, input bit survives);
    fifo_r.push_back(w);
    if (survives) exp_r.push_back(w);
  endtask

  task automatic load_c(input logic [OPT_W-1:0] w, input bit survives);
    fifo_c.push_back(w);
    if (survives) exp_c.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo_r.size() + fifo_c.size() + exp_r.size() + exp_c.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s drain_timeout left=%0d need=0", name,
               fifo_r.size() + fifo_c.size() + exp_r.size() + exp_c.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({read_from_fifo_r, read_from_fifo_c, put_back_to_FIFO_r, put_back_to_FIFO_c, solved} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b need=00000",
        {read_from_fifo_r, read_from_fifo_c, put_back_to_FIFO_r, put_back_to_FIFO_c, solved});
    end else $display("reset_strobes ok");
    total++;
    if ((known | assigned) !== '0) begin
      bad++; $display("FAIL reset_board got=%h need=0", known | assigned);
    end else $display("reset_board ok");
    // Start a row line with three options, then reset while it is mid-stream.
    apply_reset(4'd11, 4'd11);
    set_counts(1);
    amnt[0 +: CNT_W] = CNT_W'(3);
    load_r(16'd0, 1'b1);
    pulse_start();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    total++;
    if ({read_from_fifo_r, read_from_fifo_c, put_back_to_FIFO_r, put_back_to_FIFO_c, solved} !== 5'b0) begin
      bad++; $display("FAIL midrst_strobes got=%b need=00000",
        {read_from_fifo_r, read_from_fifo_c, put_back_to_FIFO_r, put_back_to_FIFO_c, solved});
    end else $display("midrst_strobes ok");
    total++;
    if ({new_option_r, new_option_c} !== '0) begin
      bad++; $display("FAIL midrst_words got=%h need=0", {new_option_r, new_option_c});
    end else $display("midrst_words ok");
    total++;
    if (exp_r.size() != 0) begin
      bad++; $display("FAIL midrst_index_push got=missing need=0000");
    end else $display("midrst_index_push ok");
    apply_reset(4'd11, 4'd11);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ((reads_r + reads_c) != 0 || known !== '0) begin
      bad++; $display("FAIL postrst_idle got=reads %0d known %h need=0", reads_r + reads_c, known);
    end else $display("postrst_idle ok");
  endtask

  task automatic test_row_full();
    apply_reset(4'd11, 4'd11);
    set_counts(1);
    load_r(16'd0, 1'b1);
    load_r(16'h07FF, 1'b1);
    pulse_start();
    wait_drain("row0");
    total++;
    if (known[10:0] !== 11'h7FF || known[NCELLS-1:11] !== '0) begin
      bad++; $display("FAIL row0_known got=%h need=7ff", known);
    end else $display("row0_known ok");
    total++;
    if (assigned[10:0] !== 11'h7FF) begin
      bad++; $display("FAIL row0_assigned got=%h need=7ff", assigned[10:0]);
    end else $display("row0_assigned ok");
    // Second row while the lane is still running.
    load_r(16'd1, 1'b1);
    load_r(16'h05FD, 1'b1);
    wait_drain("row1");
    total++;
    if (known[21:11] !== 11'h7FF) begin
      bad++; $display("FAIL row1_known got=%h need=7ff", known[21:11]);
    end else $display("row1_known ok");
    total++;
    if (assigned[21:11] !== 11'h5FD || assigned[12] !== 1'b0 || assigned[20] !== 1'b0) begin
      bad++; $display("FAIL row1_assigned got=%h need=5fd", assigned[21:11]);
    end else $display("row1_assigned ok");
  endtask

  task automatic test_back_to_back_solve();
    logic [NCELLS-1:0] exp_a;
    logic [OPT_W-1:0]  w;
    int n;
    apply_reset(4'd11, 4'd11);
    set_counts(1);
    exp_a = '0;
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 11; c++) if (c == r || c == 10 - r) exp_a[r*11 + c] = 1'b1;
      w = '0;
      w[r] = 1'b1;
      w[10 - r] = 1'b1;
      load_r(OPT_W'(r), 1'b1);
      load_r(w, 1'b1);
    end
    pulse_start();
    n = 0;
    while (solved !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (solved !== 1'b1) begin
      bad++; $display("FAIL x_solved got=%b need=1", solved);
    end else $display("x_solved ok after %0d cycles", n);
    total++;
    if (known !== '1) begin
      bad++; $display("FAIL x_known got=%h need=all ones", known);
    end else $display("x_known ok");
    total++;
    if (assigned !== exp_a) begin
      bad++; $display("FAIL x_assigned got=%h need=%h", assigned, exp_a);
    end else $display("x_assigned ok");
    total++;
    if (exp_r.size() != 0) begin
      bad++; $display("FAIL x_pushes got=%0d_missing need=0", exp_r.size());
    end else $display("x_pushes ok");
    repeat (10) @(posedge clk);
    reads_r = 0;
    reads_c = 0;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ((reads_r + reads_c) != 0 || solved !== 1'b1) begin
      bad++; $display("FAIL x_restart got=reads %0d solved %b need=0 1", reads_r + reads_c, solved);
    end else $display("x_restart ok");
  endtask

  task automatic test_partial();
    apply_reset(4'd5, 4'd5);
    set_counts(1);
    amnt[0 +: CNT_W] = CNT_W'(2);
    load_r(16'd0, 1'b1);
    load_r(16'h0007, 1'b1);
    load_r(16'h000E, 1'b1);
    pulse_start();
    wait_drain("partial");
    total++;
    if (known[4:0] !== 5'b10110 || known[NCELLS-1:5] !== '0) begin
      bad++; $display("FAIL partial_known got=%h need=16", known);
    end else $display("partial_known ok");
    total++;
    if ((assigned[4:0] & known[4:0]) !== 5'b00110) begin
      bad++; $display("FAIL partial_assigned got=%b need=00110", assigned[4:0] & known[4:0]);
    end else $display("partial_assigned ok");
    total++;
    if (solved !== 1'b0) begin
      bad++; $display("FAIL partial_solved got=%b need=0", solved);
    end else $display("partial_solved ok");
  endtask

  task automatic test_contradiction();
    logic [NCELLS-1:0] exp_k;
    logic [NCELLS-1:0] exp_a;
    apply_reset(4'd5, 4'd5);
    set_counts(1);
    exp_k = '0;
    for (int r = 0; r < 5; r++) exp_k[r*5] = 1'b1;
    exp_a = '0;
    exp_a[0] = 1'b1;
    load_c(16'd5, 1'b1);
    load_c(16'h0001, 1'b1);
    pulse_start();
    wait_drain("col0");
    total++;
    if (known !== exp_k || assigned !== exp_a) begin
      bad++; $display("FAIL col0_board got=%h/%h need=%h/%h", known, assigned, exp_k, exp_a);
    end else $display("col0_board ok");
    load_r(16'd0, 1'b1);
    load_r(16'h001E, 1'b0);
    wait_drain("contra");
    total++;
    if (known !== exp_k) begin
      bad++; $display("FAIL contra_known got=%h need=%h", known, exp_k);
    end else $display("contra_known ok");
    total++;
    if (assigned !== exp_a) begin
      bad++; $display("FAIL contra_assigned got=%h need=%h", assigned, exp_a);
    end else $display("contra_assigned ok");
  endtask

  initial begin
    test_reset();
    test_row_full();
    test_back_to_back_solve();
    test_partial();
    test_contradiction();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
